// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Holds the FSM state type, the default operand width and the counter-width helper.
package serial_sub_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Bit-counter width for a WIDTH-bit operand; kept at least one bit wide.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/half_subtractor.sv
// One-bit half subtractor: diff = x - y, borrow set when x < y.
// Two of these plus an OR gate form the full-subtractor cell.
module half_subtractor (
    input  logic x,
    input  logic y,
    output logic diff,
    output logic borrow
);

    assign diff   = x ^ y;
    assign borrow = ~x & y;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor computing A - B LSB-first with a final borrow flag.
// Define SERIAL_SUB_PARALLEL_OUT_EN to add the diff_word parallel result port.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             a_bit,
    input  logic             b_bit,
    input  logic             bit_valid,
    output logic             diff_bit,
    output logic             diff_valid,
    output logic             busy,
    output logic             done,
    output logic             borrow_out
`ifdef SERIAL_SUB_PARALLEL_OUT_EN
    ,
    output logic [WIDTH-1:0] diff_word
`endif
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

    state_t          r_state;
    state_t          w_next_state;
    logic [CW-1:0]   r_cnt;
    logic            r_borrow;
    logic            r_diff_bit;
    logic            r_diff_valid;
    logic            r_done;
    logic            r_borrow_out;

    logic            w_start;
    logic            w_accept;
    logic            w_last;
    logic            w_busy;
    logic            w_d1;
    logic            w_b1;
    logic            w_b2;
    logic            w_diff;
    logic            w_borrow_next;

    // Full-subtractor cell: (a - b) first, then subtract the running borrow.
    half_subtractor u_hs_ab (
        .x      (a_bit),
        .y      (b_bit),
        .diff   (w_d1),
        .borrow (w_b1)
    );

    half_subtractor u_hs_bw (
        .x      (w_d1),
        .y      (r_borrow),
        .diff   (w_diff),
        .borrow (w_b2)
    );

    assign w_borrow_next = w_b1 | w_b2;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: the default assignment up front keeps this block free of inferred latches.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start)              w_next_state = RUN;
            RUN:     if (w_accept && w_last) w_next_state = IDLE;
            default:                         w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_start  = (r_state == IDLE) && start;
        w_accept = (r_state == RUN) && bit_valid;
        w_last   = (r_cnt == LAST_CNT);
        w_busy   = (r_state == RUN);
    end

    // The counter holds at WIDTH-1 on the last beat; the next start clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_borrow     <= 1'b0;
            r_diff_bit   <= 1'b0;
            r_diff_valid <= 1'b0;
            r_done       <= 1'b0;
            r_borrow_out <= 1'b0;
        end else begin
            r_diff_valid <= w_accept;
            r_done       <= w_accept && w_last;
            if (w_start) begin
                r_cnt        <= '0;
                r_borrow     <= 1'b0;
                r_borrow_out <= 1'b0;
            end else if (w_accept) begin
                r_diff_bit <= w_diff;
                r_borrow   <= w_borrow_next;
                if (w_last) begin
                    r_borrow_out <= w_borrow_next;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

`ifdef SERIAL_SUB_PARALLEL_OUT_EN
    logic [WIDTH-1:0] r_diff_word;

    // LSB-first bits enter at the MSB and shift right, landing in place after WIDTH beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_diff_word <= '0;
        end else if (w_accept) begin
            r_diff_word <= {w_diff, r_diff_word[WIDTH-1:1]};
        end
    end

    assign diff_word = r_diff_word;
`endif

    assign diff_bit   = r_diff_bit;
    assign diff_valid = r_diff_valid;
    assign busy       = w_busy;
    assign done       = r_done;
    assign borrow_out = r_borrow_out;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): driver queues expected beats, monitor compares.
// Checks diff_word too when SERIAL_SUB_PARALLEL_OUT_EN is defined.
module tb_serial_subtractor;

    localparam int W = 8;

    typedef struct {
        logic         d;
        logic         last;
        logic         borrow;
        logic [W-1:0] word;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         a_bit;
    logic         b_bit;
    logic         bit_valid;
    logic         diff_bit;
    logic         diff_valid;
    logic         busy;
    logic         done;
    logic         borrow_out;
`ifdef SERIAL_SUB_PARALLEL_OUT_EN
    logic [W-1:0] diff_word;
`endif

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a_bit      (a_bit),
        .b_bit      (b_bit),
        .bit_valid  (bit_valid),
        .diff_bit   (diff_bit),
        .diff_valid (diff_valid),
        .busy       (busy),
        .done       (done),
        .borrow_out (borrow_out)
`ifdef SERIAL_SUB_PARALLEL_OUT_EN
        ,
        .diff_word  (diff_word)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every diff_valid pulse consumes one expected beat.
    always @(negedge clk) begin
        if (rst_n) begin
            if (diff_valid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_diff_valid", 64'(diff_valid), 64'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("diff_bit", 64'(diff_bit), 64'(mon_e.d));
                    check("done", 64'(done), 64'(mon_e.last));
                    if (mon_e.last) begin
                        check("borrow_out", 64'(borrow_out), 64'(mon_e.borrow));
`ifdef SERIAL_SUB_PARALLEL_OUT_EN
                        check("diff_word", 64'(diff_word), 64'(mon_e.word));
`endif
                    end
                end
            end else begin
                check("done_without_valid", 64'(done), 64'd0);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain modular subtraction; borrow is simply A < B.
    task automatic push_expected(input logic [W-1:0] a, input logic [W-1:0] b, input int n_beats);
        logic [W-1:0] d;
        exp_t         e;
        d = a - b;
        for (int i = 0; i < n_beats; i++) begin
            e.d      = d[i];
            e.last   = (i == W - 1);
            e.borrow = (a < b);
            e.word   = d;
            sb_q.push_back(e);
        end
    endtask

    // gap_mode: 0 continuous, 1 two stall cycles per beat, 2 random stalls with noise.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int gap_mode, input bit b2b);
        int n_gap;
        push_expected(a, b, W);
        start     = 1'b1;
        bit_valid = 1'($urandom);
        a_bit     = 1'($urandom);
        b_bit     = 1'($urandom);
        cyc();
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        for (int i = 0; i < W; i++) begin
            n_gap = (gap_mode == 1) ? 2 : (gap_mode == 2) ? int'($urandom_range(0, 3)) : 0;
            repeat (n_gap) begin
                bit_valid = 1'b0;
                start     = 1'($urandom);
                a_bit     = 1'($urandom);
                b_bit     = 1'($urandom);
                cyc();
            end
            start     = 1'b0;
            bit_valid = 1'b1;
            a_bit     = a[i];
            b_bit     = b[i];
            cyc();
        end
        bit_valid = 1'b0;
        check("done_after_last_beat", 64'(done), 64'd1);
        check("busy_after_last_beat", 64'(busy), 64'd0);
        if (!b2b) begin
            repeat (2) begin
                bit_valid = 1'($urandom);
                a_bit     = 1'($urandom);
                b_bit     = 1'($urandom);
                cyc();
            end
            bit_valid = 1'b0;
            check("borrow_out_held", 64'(borrow_out), 64'(a < b));
            check("busy_idle", 64'(busy), 64'd0);
        end
    endtask

    task automatic reset_mid_op();
        logic [W-1:0] a;
        logic [W-1:0] b;
        a = 8'h5A;
        b = 8'h33;
        push_expected(a, b, 2);
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bit_valid = 1'b1;
            a_bit     = a[i];
            b_bit     = b[i];
            cyc();
        end
        bit_valid = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_diff_bit", 64'(diff_bit), 64'd0);
        check("rst_mid_diff_valid", 64'(diff_valid), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_done", 64'(done), 64'd0);
        check("rst_mid_borrow_out", 64'(borrow_out), 64'd0);
        check("rst_mid_sb_empty", 64'(sb_q.size()), 64'd0);
        cyc();
        #2;
        rst_n = 1'b1;
        cyc();
        check("rst_mid_still_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        a_bit     = 1'b0;
        b_bit     = 1'b0;
        bit_valid = 1'b0;
        #1;
        check("reset_diff_bit", 64'(diff_bit), 64'd0);
        check("reset_diff_valid", 64'(diff_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_borrow_out", 64'(borrow_out), 64'd0);
`ifdef SERIAL_SUB_PARALLEL_OUT_EN
        check("reset_diff_word", 64'(diff_word), 64'd0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        run_op(8'd5,  8'd3,  0, 1'b0);
        run_op(8'd3,  8'd5,  0, 1'b0);
        run_op(8'h80, 8'h01, 1, 1'b0);
        run_op(8'hC3, 8'h3C, 2, 1'b0);
        run_op(8'h00, 8'hFF, 0, 1'b0);
        run_op(8'hFF, 8'h00, 2, 1'b0);
        reset_mid_op();
        run_op(8'd9,  8'd9,  0, 1'b0);
        run_op(8'h10, 8'h20, 0, 1'b1);
        run_op(8'hAB, 8'h0C, 0, 1'b0);
        for (int k = 0; k < 40; k++) begin
            run_op(W'($urandom), W'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
        end
        bit_valid = 1'b0;
        start     = 1'b0;

        for (int k = 0; k < 50 && sb_q.size() != 0; k++) cyc();
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        repeat (2) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
